texture_filter_bilinear: RTL and testbench

- Consumes the texel quad (texel00/01/10/11) and Q0.16 sub-texel coordinates produced by the texture sampler.
- Produces one filtered RGBA8888 texel per accepted input, either bilinear-interpolated or nearest-selected.
- 3-stage pipeline with a global clock enable and a valid/tag sideband, feeding the texture environment / colour combiner stage.

---
 rtl/texture_filter_bilinear_if.sv | 37 +++
 rtl/texture_filter_bilinear.sv | 118 +++++++++++
 tb/tb_texture_filter_bilinear.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/texture_filter_bilinear_if.sv
// Texel quad request from the sampler and filtered texel result toward the
// colour combiner, grouped as one bundle.
interface texture_filter_bilinear_if #(
  parameter int PIXEL_WIDTH = 32,
  parameter int TAG_WIDTH   = 16
);

  logic                   s_valid;
  logic [TAG_WIDTH-1:0]   s_tag;
  logic                   enableBilinear;
  logic [PIXEL_WIDTH-1:0] texel00;
  logic [PIXEL_WIDTH-1:0] texel01;
  logic [PIXEL_WIDTH-1:0] texel10;
  logic [PIXEL_WIDTH-1:0] texel11;
  logic [15:0]            texelSubCoordS;
  logic [15:0]            texelSubCoordT;

  logic                   m_valid;
  logic [TAG_WIDTH-1:0]   m_tag;
  logic [PIXEL_WIDTH-1:0] texelOut;

  // master = texture sampler side, slave = filter side
  modport master (
    output s_valid, s_tag, enableBilinear,
    output texel00, texel01, texel10, texel11,
    output texelSubCoordS, texelSubCoordT,
    input  m_valid, m_tag, texelOut
  );

  modport slave (
    input  s_valid, s_tag, enableBilinear,
    input  texel00, texel01, texel10, texel11,
    input  texelSubCoordS, texelSubCoordT,
    output m_valid, m_tag, texelOut
  );

endinterface

// File: rtl/texture_filter_bilinear.sv
// Three-stage bilinear / nearest texture filter: horizontal lerps, vertical
// lerp, then mode select, all advancing together under a global clock enable.
module texture_filter_bilinear #(
  parameter int PIXEL_WIDTH = 32,
  parameter int TAG_WIDTH   = 16
) (
  input  logic                       aclk,
  input  logic                       reset,
  input  logic                       ce,
  texture_filter_bilinear_if.slave   bus
);

  localparam int LANES = PIXEL_WIDTH / 8;

  // Rounded 8-bit lerp; worst case 255*256+128 fits in 17 bits and the
  // shifted result never exceeds 255, so no saturation is needed.
  function automatic logic [7:0] lerp8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] w);
    return 8'(({9'd0, a} * (17'd256 - {9'd0, w}) + {9'd0, b} * {9'd0, w} + 17'd128) >> 8);
  endfunction

  function automatic logic [PIXEL_WIDTH-1:0] lerpPixel(input logic [PIXEL_WIDTH-1:0] a,
                                                       input logic [PIXEL_WIDTH-1:0] b,
                                                       input logic [7:0] w);
    logic [PIXEL_WIDTH-1:0] res;
    res = '0;
    for (int lane = 0; lane < LANES; lane++) begin
      res[8*lane +: 8] = lerp8(a[8*lane +: 8], b[8*lane +: 8], w);
    end
    return res;
  endfunction

  logic [7:0]             wu;
  logic [7:0]             wv;
  logic [PIXEL_WIDTH-1:0] topComb;
  logic [PIXEL_WIDTH-1:0] bottomComb;
  logic [PIXEL_WIDTH-1:0] nearestComb;
  logic                   unusedCoordBits;

  logic                   s1Valid;
  logic [TAG_WIDTH-1:0]   s1Tag;
  logic                   s1Mode;
  logic [7:0]             s1Wv;
  logic [PIXEL_WIDTH-1:0] s1Top;
  logic [PIXEL_WIDTH-1:0] s1Bottom;
  logic [PIXEL_WIDTH-1:0] s1Nearest;

  logic                   s2Valid;
  logic [TAG_WIDTH-1:0]   s2Tag;
  logic                   s2Mode;
  logic [PIXEL_WIDTH-1:0] s2Mix;
  logic [PIXEL_WIDTH-1:0] s2Nearest;

  logic                   outValid;
  logic [TAG_WIDTH-1:0]   outTag;
  logic [PIXEL_WIDTH-1:0] outTexel;

  // Only the top byte of each Q0.16 fraction acts as a weight.
  assign wu              = bus.texelSubCoordS[15:8];
  assign wv              = bus.texelSubCoordT[15:8];
  assign unusedCoordBits = ^{bus.texelSubCoordS[7:0], bus.texelSubCoordT[7:0]};

  always_comb begin
    topComb     = lerpPixel(bus.texel00, bus.texel01, wu);
    bottomComb  = lerpPixel(bus.texel10, bus.texel11, wu);
    nearestComb = bus.texel00;
    case ({bus.texelSubCoordT[15], bus.texelSubCoordS[15]})
      2'b00:   nearestComb = bus.texel00;
      2'b01:   nearestComb = bus.texel01;
      2'b10:   nearestComb = bus.texel10;
      default: nearestComb = bus.texel11;
    endcase
  end

  // Every register, valid bits included, holds while ce is low.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      s1Valid   <= 1'b0;
      s1Tag     <= '0;
      s1Mode    <= 1'b0;
      s1Wv      <= '0;
      s1Top     <= '0;
      s1Bottom  <= '0;
      s1Nearest <= '0;
      s2Valid   <= 1'b0;
      s2Tag     <= '0;
      s2Mode    <= 1'b0;
      s2Mix     <= '0;
      s2Nearest <= '0;
      outValid  <= 1'b0;
      outTag    <= '0;
      outTexel  <= '0;
    end else if (ce) begin
      s1Valid   <= bus.s_valid;
      s1Tag     <= bus.s_tag;
      s1Mode    <= bus.enableBilinear;
      s1Wv      <= wv;
      s1Top     <= topComb;
      s1Bottom  <= bottomComb;
      s1Nearest <= nearestComb;

      s2Valid   <= s1Valid;
      s2Tag     <= s1Tag;
      s2Mode    <= s1Mode;
      s2Mix     <= lerpPixel(s1Top, s1Bottom, s1Wv);
      s2Nearest <= s1Nearest;

      outValid  <= s2Valid;
      outTag    <= s2Tag;
      outTexel  <= s2Mode ? s2Mix : s2Nearest;
    end
  end

  assign bus.m_valid  = outValid;
  assign bus.m_tag    = outTag;
  assign bus.texelOut = outTexel;

endmodule

// File: tb/tb_texture_filter_bilinear.sv
// Self-checking bench for texture_filter_bilinear: directed corner cases plus
// randomized traffic against a per-ce-cycle history model of the filter.
module tb_texture_filter_bilinear;

  logic aclk;
  logic reset;
  logic ce;

  texture_filter_bilinear_if #(.PIXEL_WIDTH(32), .TAG_WIDTH(16)) bus ();

  texture_filter_bilinear #(.PIXEL_WIDTH(32), .TAG_WIDTH(16)) dut (
    .aclk  (aclk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  // One entry per accepted (ce=1) cycle; output after edge n shows entry n-2.
  bit          histValid[$];
  logic [15:0] histTag[$];
  logic [31:0] histData[$];
  logic        expValid;
  logic [15:0] expTag;
  logic [31:0] expData;

  function automatic logic [31:0] refTexel(input logic [31:0] t00, input logic [31:0] t01,
                                           input logic [31:0] t10, input logic [31:0] t11,
                                           input logic [15:0] s, input logic [15:0] t,
                                           input bit mode);
    int wu, wv, top, bot, mix;
    logic [31:0] res;
    wu  = int'(s) / 256;
    wv  = int'(t) / 256;
    res = '0;
    if (!mode) begin
      if (t >= 16'h8000) return (s >= 16'h8000) ? t11 : t10;
      else               return (s >= 16'h8000) ? t01 : t00;
    end
    for (int ch = 0; ch < 4; ch++) begin
      top = (int'(t00[8*ch +: 8]) * (256 - wu) + int'(t01[8*ch +: 8]) * wu + 128) / 256;
      bot = (int'(t10[8*ch +: 8]) * (256 - wu) + int'(t11[8*ch +: 8]) * wu + 128) / 256;
      mix = (top * (256 - wv) + bot * wv + 128) / 256;
      res[8*ch +: 8] = 8'(mix);
    end
    return res;
  endfunction

  task automatic clockIn(input bit ceIn, input bit vIn, input bit modeIn, input logic [15:0] tagIn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [15:0] s, input logic [15:0] t);
    int n;
    ce                 = ceIn;
    bus.s_valid        = vIn;
    bus.enableBilinear = modeIn;
    bus.s_tag          = tagIn;
    bus.texel00        = a;
    bus.texel01        = b;
    bus.texel10        = c;
    bus.texel11        = d;
    bus.texelSubCoordS = s;
    bus.texelSubCoordT = t;
    @(posedge aclk);
    #1;
    if (ceIn) begin
      histValid.push_back(vIn);
      histTag.push_back(tagIn);
      histData.push_back(refTexel(a, b, c, d, s, t, modeIn));
    end
    n = histValid.size();
    if (n >= 3) begin
      expValid = histValid[n-3];
      expTag   = histTag[n-3];
      expData  = histData[n-3];
    end else begin
      expValid = 1'b0;
      expTag   = '0;
      expData  = '0;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) clockIn(1'b1, 1'b0, 1'b0, 16'h0, '0, '0, '0, '0, 16'h0, 16'h0);
  endtask

  // Pushes one quad through an emptied pipe and reports what came out.
  task automatic runOne(input bit modeIn, input logic [15:0] tagIn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d,
                        input logic [15:0] s, input logic [15:0] t,
                        output logic early, output logic gotValid,
                        output logic [15:0] gotTag, output logic [31:0] gotTexel);
    flush();
    clockIn(1'b1, 1'b1, modeIn, tagIn, a, b, c, d, s, t);
    early = bus.m_valid;
    clockIn(1'b1, 1'b0, 1'b0, 16'h0, '0, '0, '0, '0, 16'h0, 16'h0);
    early = early | bus.m_valid;
    clockIn(1'b1, 1'b0, 1'b0, 16'h0, '0, '0, '0, '0, 16'h0, 16'h0);
    gotValid = bus.m_valid;
    gotTag   = bus.m_tag;
    gotTexel = bus.texelOut;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce    = 1'b0;
    bus.s_valid = 1'b0; bus.s_tag = '0; bus.enableBilinear = 1'b0;
    bus.texel00 = '0; bus.texel01 = '0; bus.texel10 = '0; bus.texel11 = '0;
    bus.texelSubCoordS = '0; bus.texelSubCoordT = '0;
    #1;
    total++; if (bus.m_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.texelOut !== 32'h0) begin bad++; $display("[TB] FAIL reset_texel: got %h want 0", bus.texelOut); end
    total++; if (bus.m_tag !== 16'h0)    begin bad++; $display("[TB] FAIL reset_tag: got %h want 0", bus.m_tag); end
    ce = 1'b1; bus.s_valid = 1'b1; bus.s_tag = 16'hBEEF; bus.texel00 = 32'hDEADBEEF;
    @(posedge aclk); #1;
    total++; if (bus.m_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_hold_valid: got %b want 0", bus.m_valid); end
    #1 reset = 1'b0;
    histValid.delete(); histTag.delete(); histData.delete();
  endtask

  task automatic test_uniform();
    logic early, v; logic [15:0] tg; logic [31:0] tx;
    runOne(1'b1, 16'h00A1, 32'h80402010, 32'h80402010, 32'h80402010, 32'h80402010,
           16'hFFFF, 16'h1234, early, v, tg, tx);
    total++; if (early !== 1'b0)        begin bad++; $display("[TB] FAIL uniform_early: got %b want 0", early); end
    total++; if (v !== 1'b1)            begin bad++; $display("[TB] FAIL uniform_valid: got %b want 1", v); end
    total++; if (tx !== 32'h80402010)   begin bad++; $display("[TB] FAIL uniform_texel: got %h want 80402010", tx); end
    total++; if (tg !== 16'h00A1)       begin bad++; $display("[TB] FAIL uniform_tag: got %h want 00a1", tg); end
  endtask

  task automatic test_half();
    logic early, v; logic [15:0] tg; logic [31:0] tx;
    runOne(1'b1, 16'h00B2, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
           16'h8000, 16'h0000, early, v, tg, tx);
    total++; if (v !== 1'b1 || tx !== 32'h80808080) begin bad++; $display("[TB] FAIL half_lerp: got v=%b %h want v=1 80808080", v, tx); end
  endtask

  task automatic test_nearest();
    logic early, v; logic [15:0] tg; logic [31:0] tx;
    logic [15:0] sTab [3] = '{16'h7FFF, 16'h8000, 16'h0000};
    logic [15:0] tTab [3] = '{16'h8000, 16'h8000, 16'h0000};
    logic [31:0] want [3] = '{32'h33333333, 32'h44444444, 32'h11111111};
    for (int i = 0; i < 3; i++) begin
      runOne(1'b0, 16'(i + 16'h10), 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
             sTab[i], tTab[i], early, v, tg, tx);
      total++; if (v !== 1'b1 || tx !== want[i]) begin bad++; $display("[TB] FAIL nearest_%0d: got v=%b %h want v=1 %h", i, v, tx, want[i]); end
    end
  endtask

  task automatic test_boundaries();
    logic early, v; logic [15:0] tg; logic [31:0] tx;
    logic [31:0] q0, q1, q2, q3;
    runOne(1'b1, 16'h00C3, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF,
           16'hFF00, 16'h0000, early, v, tg, tx);
    total++; if (tx !== 32'hFEFEFEFE) begin bad++; $display("[TB] FAIL wu255: got %h want fefefefe", tx); end
    q0 = $urandom; q1 = $urandom; q2 = $urandom; q3 = $urandom;
    runOne(1'b1, 16'h00C4, q0, q1, q2, q3, 16'h00FF, 16'h00AB, early, v, tg, tx);
    total++; if (tx !== q0) begin bad++; $display("[TB] FAIL zero_weights: got %h want %h", tx, q0); end
    for (int m = 0; m < 2; m++) begin
      runOne(m[0], 16'h00C5, q1, q1, q1, q1, 16'($urandom), 16'($urandom), early, v, tg, tx);
      total++; if (tx !== q1) begin bad++; $display("[TB] FAIL identical_quad_mode%0d: got %h want %h", m, tx, q1); end
    end
  endtask

  task automatic test_ce_stall();
    bit          ceTab [13] = '{1,1,1,0,0,0,0,0,1,1,1,1,1};
    bit          vTab  [13] = '{1,1,1,1,1,1,1,1,1,0,0,0,0};
    logic [15:0] tagTab[13] = '{16'd1,16'd2,16'd3,16'h99,16'h99,16'h99,16'h99,16'h99,16'd4,16'd0,16'd0,16'd0,16'd0};
    logic [15:0] seen[$];
    flush();
    for (int i = 0; i < 13; i++) begin
      clockIn(ceTab[i], vTab[i], 1'($urandom), tagTab[i], $urandom, $urandom, $urandom, $urandom,
              16'($urandom), 16'($urandom));
      total++; if (bus.m_valid !== expValid) begin bad++; $display("[TB] FAIL stall_valid[%0d]: got %b want %b", i, bus.m_valid, expValid); end
      if (expValid) begin
        total++; if (bus.m_tag !== expTag)     begin bad++; $display("[TB] FAIL stall_tag[%0d]: got %h want %h", i, bus.m_tag, expTag); end
        total++; if (bus.texelOut !== expData) begin bad++; $display("[TB] FAIL stall_texel[%0d]: got %h want %h", i, bus.texelOut, expData); end
      end
      if (ceTab[i] && bus.m_valid === 1'b1) seen.push_back(bus.m_tag);
    end
    total++; if (seen.size() != 4) begin bad++; $display("[TB] FAIL stall_count: got %0d want 4", seen.size()); end
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      total++; if (seen[i] !== 16'(i + 1)) begin bad++; $display("[TB] FAIL stall_order[%0d]: got %h want %h", i, seen[i], i + 1); end
    end
  endtask

  task automatic test_async_reset();
    flush();
    for (int i = 0; i < 3; i++)
      clockIn(1'b1, 1'b1, 1'b1, 16'(16'h31 + i), $urandom, $urandom, $urandom, $urandom,
              16'($urandom), 16'($urandom));
    #2 reset = 1'b1;
    #1;
    total++; if (bus.m_valid !== 1'b0)   begin bad++; $display("[TB] FAIL async_reset_valid: got %b want 0", bus.m_valid); end
    total++; if (bus.texelOut !== 32'h0) begin bad++; $display("[TB] FAIL async_reset_texel: got %h want 0", bus.texelOut); end
    total++; if (bus.m_tag !== 16'h0)    begin bad++; $display("[TB] FAIL async_reset_tag: got %h want 0", bus.m_tag); end
    histValid.delete(); histTag.delete(); histData.delete();
    @(posedge aclk);
    #2 reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      clockIn(1'b1, (i == 2), 1'b1, 16'h77, $urandom, $urandom, $urandom, $urandom,
              16'($urandom), 16'($urandom));
      total++; if (bus.m_valid !== expValid) begin bad++; $display("[TB] FAIL post_reset_valid[%0d]: got %b want %b", i, bus.m_valid, expValid); end
      if (expValid) begin
        total++; if (bus.texelOut !== expData) begin bad++; $display("[TB] FAIL post_reset_texel[%0d]: got %h want %h", i, bus.texelOut, expData); end
      end
    end
  endtask

  task automatic test_valid_toggle();
    bit vTab[9] = '{1,0,1,0,1,1,0,0,0};
    bit mTab[9] = '{1,0,0,1,1,0,0,0,0};
    flush();
    for (int i = 0; i < 9; i++) begin
      clockIn(1'b1, vTab[i], mTab[i], 16'(16'h200 + i), $urandom, $urandom, $urandom, $urandom,
              16'($urandom), 16'($urandom));
      total++; if (bus.m_valid !== expValid) begin bad++; $display("[TB] FAIL toggle_valid[%0d]: got %b want %b", i, bus.m_valid, expValid); end
      if (expValid) begin
        total++; if (bus.texelOut !== expData) begin bad++; $display("[TB] FAIL toggle_texel[%0d]: got %h want %h", i, bus.texelOut, expData); end
        total++; if (bus.m_tag !== expTag)     begin bad++; $display("[TB] FAIL toggle_tag[%0d]: got %h want %h", i, bus.m_tag, expTag); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [31:0] q0, q1, q2, q3;
      q0 = $urandom; q1 = $urandom; q2 = $urandom; q3 = $urandom;
      if ($urandom_range(7) == 0) begin q1 = q0; q2 = q0; q3 = q0; end
      clockIn($urandom_range(3) != 0, 1'($urandom), 1'($urandom), 16'($urandom), q0, q1, q2, q3,
              16'($urandom), 16'($urandom));
      total++; if (bus.m_valid !== expValid) begin bad++; $display("[TB] FAIL rand_valid[%0d]: got %b want %b", i, bus.m_valid, expValid); end
      if (expValid) begin
        total++; if (bus.texelOut !== expData) begin bad++; $display("[TB] FAIL rand_texel[%0d]: got %h want %h", i, bus.texelOut, expData); end
        total++; if (bus.m_tag !== expTag)     begin bad++; $display("[TB] FAIL rand_tag[%0d]: got %h want %h", i, bus.m_tag, expTag); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_half();
    test_nearest();
    test_boundaries();
    test_ce_stall();
    test_async_reset();
    test_valid_toggle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
